priority_scan_display: RTL and testbench

- Parametrised, clocked successor to the single-digit priority-encode-to-7-segment path.
- Registers an N_IN-bit request vector and finds the highest set bit index.
- Converts that index to decimal and time-multiplexes it across DIGITS seven-segment digits with leading-zero blanking.
- Adds a hold (freeze) mode.
- Sits between board switches or a request bus and the board's shared-segment, per-digit-anode LED display.

---
 rtl/priority_scan_display.sv | 121 ++++++++++++
 tb/tb_priority_scan_display.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/priority_scan_display.sv
// priority_scan_display: registers a request vector, captures the index of its
// highest set bit, converts the index to decimal and scans it across DIGITS
// seven-segment digits. Segments and anodes are active-low, and leading zeros
// are blanked. While hold is high the captured index is frozen, but the display
// keeps scanning.
module priority_scan_display #(
    parameter int N_IN     = 16,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 50000,
    parameter int IDX_W    = $clog2(N_IN)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_IN-1:0]   x,
    input  logic              en,
    input  logic              hold,
    output logic [IDX_W-1:0]  idx,
    output logic              valid,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] an
);

    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int PTR_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    // Active-low {g,f,e,d,c,b,a} pattern for one decimal digit
    function automatic logic [6:0] seg_pattern(input logic [3:0] d);
        case (d)
            4'd0:    seg_pattern = 7'b1000000;
            4'd1:    seg_pattern = 7'b1111001;
            4'd2:    seg_pattern = 7'b0100100;
            4'd3:    seg_pattern = 7'b0110000;
            4'd4:    seg_pattern = 7'b0011001;
            4'd5:    seg_pattern = 7'b0010010;
            4'd6:    seg_pattern = 7'b0000010;
            4'd7:    seg_pattern = 7'b1111000;
            4'd8:    seg_pattern = 7'b0000000;
            4'd9:    seg_pattern = 7'b0010000;
            default: seg_pattern = 7'b1111111;
        endcase
    endfunction

    logic [IDX_W-1:0] top_idx;
    logic [CNT_W-1:0] scan_cnt;
    logic [PTR_W-1:0] ptr;
    logic             scan_wrap;
    logic [31:0]      idx_ext;
    logic [3:0]       digit_val  [DIGITS];
    logic             lead_blank [DIGITS];
    logic [3:0]       sel_val;
    logic             sel_lead;

    // Priority encoder: the highest set bit overrides lower bits (0 when x is zero)
    always_comb begin
        top_idx = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (x[i]) top_idx = IDX_W'(i);
        end
    end

    // Capture stage: sample the index and valid unless frozen by hold
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx   <= '0;
            valid <= 1'b0;
        end else if (!hold) begin
            idx   <= top_idx;
            valid <= |x;
        end
    end

    assign scan_wrap = (scan_cnt == CNT_W'(SCAN_DIV - 1));

    // Scan timer: each digit stays selected for SCAN_DIV cycles; the pointer wraps at DIGITS
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            ptr      <= '0;
        end else if (scan_wrap) begin
            scan_cnt <= '0;
            ptr      <= (ptr == PTR_W'(DIGITS - 1)) ? '0 : ptr + PTR_W'(1);
        end else begin
            scan_cnt <= scan_cnt + CNT_W'(1);
        end
    end

    // Decimal conversion by constant divide/modulo for each digit position
    assign idx_ext = 32'(idx);

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            localparam int POW = 10 ** gi;
            assign digit_val[gi]  = 4'((idx_ext / 32'(POW)) % 32'd10);
            assign lead_blank[gi] = (gi > 0) && (idx_ext < 32'(POW));
        end
    endgenerate

    // Select the digit value and blanking flag for the current scan pointer
    always_comb begin
        sel_val  = '0;
        sel_lead = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (ptr == PTR_W'(i)) begin
                sel_val  = digit_val[i];
                sel_lead = lead_blank[i];
            end
        end
    end

    // Output register: the anode follows the pointer; segments blank on !en, !valid or a leading zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an  <= '1;
            seg <= 7'b1111111;
        end else begin
            an  <= ~(DIGITS'(1) << ptr);
            seg <= (!en || !valid || sel_lead) ? 7'b1111111 : seg_pattern(sel_val);
        end
    end

endmodule

// File: tb/tb_priority_scan_display.sv
// Directed bench for priority_scan_display with N_IN=16, DIGITS=2, SCAN_DIV=4.
module tb_priority_scan_display;

    localparam int N_IN     = 16;
    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 4;
    localparam int IDX_W    = $clog2(N_IN);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N_IN-1:0]   x = '0;
    logic              en = 1'b1;
    logic              hold = 1'b0;
    logic [IDX_W-1:0]  idx;
    logic              valid;
    logic [6:0]        seg;
    logic [DIGITS-1:0] an;

    int total = 0;
    int bad   = 0;

    localparam logic [6:0] BLANK = 7'b1111111;

    priority_scan_display #(
        .N_IN(N_IN), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .en(en), .hold(hold),
        .idx(idx), .valid(valid), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    // Reference segment value for digit position p of a displayed index
    function automatic logic [6:0] ref_seg(input int v_idx, input bit v_valid, input bit v_en, input int p);
        logic [6:0] pat [10];
        int pw;
        pat = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        pw = (p == 0) ? 1 : 10;
        if (!v_en || !v_valid || (p > 0 && v_idx < pw)) return BLANK;
        return pat[(v_idx / pw) % 10];
    endfunction

    // Wait (bounded) until an equals target at a negedge sample
    task automatic wait_an(input logic [DIGITS-1:0] target, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (an === target) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset;
        bit ok;
        rst_n = 1'b0; x = '0; en = 1'b1; hold = 1'b0;
        #12;
        total++; if (idx !== 4'd0 || valid !== 1'b0) begin bad++; $display("FAIL reset_cap idx=%0d valid=%0b want 0/0", idx, valid); end
        total++; if (an !== 2'b11 || seg !== BLANK) begin bad++; $display("FAIL reset_out an=%b seg=%b want 11/1111111", an, seg); end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        total++; if (an !== 2'b10) begin bad++; $display("FAIL reset_first_digit an=%b want 10", an); end
        wait_an(2'b01, ok);
        total++; if (!ok) begin bad++; $display("FAIL reset_scan_timeout an=%b want 01", an); end
        $display("test_reset done");
    endtask

    task automatic test_single_digit;
        bit ok;
        int n;
        @(negedge clk); x = 16'h0001; en = 1'b1;
        @(negedge clk);
        total++; if (idx !== 4'd0 || valid !== 1'b1) begin bad++; $display("FAIL single_cap idx=%0d valid=%0b want 0/1", idx, valid); end
        wait_an(2'b10, ok);
        total++; if (!ok || seg !== 7'b1000000) begin bad++; $display("FAIL single_d0 seg=%b want 1000000", seg); end
        wait_an(2'b01, ok);
        total++; if (!ok || seg !== BLANK) begin bad++; $display("FAIL single_d1 seg=%b want 1111111", seg); end
        wait_an(2'b10, ok);
        n = 1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (an !== 2'b10) break;
            n++;
        end
        total++; if (!ok || n !== SCAN_DIV) begin bad++; $display("FAIL single_period cycles=%0d want %0d", n, SCAN_DIV); end
        $display("test_single_digit x=0001 idx=%0d", idx);
    endtask

    task automatic test_priority;
        bit ok;
        @(negedge clk); x = 16'h8021;
        repeat (2) @(negedge clk);
        total++; if (idx !== 4'd15 || valid !== 1'b1) begin bad++; $display("FAIL prio_cap idx=%0d valid=%0b want 15/1", idx, valid); end
        wait_an(2'b10, ok);
        total++; if (!ok || seg !== 7'b0010010) begin bad++; $display("FAIL prio15_d0 seg=%b want 0010010", seg); end
        wait_an(2'b01, ok);
        total++; if (!ok || seg !== 7'b1111001) begin bad++; $display("FAIL prio15_d1 seg=%b want 1111001", seg); end
        @(negedge clk); x = 16'h0200;
        repeat (2) @(negedge clk);
        total++; if (idx !== 4'd9) begin bad++; $display("FAIL prio9_cap idx=%0d want 9", idx); end
        wait_an(2'b10, ok);
        total++; if (!ok || seg !== 7'b0010000) begin bad++; $display("FAIL prio9_d0 seg=%b want 0010000", seg); end
        wait_an(2'b01, ok);
        total++; if (!ok || seg !== BLANK) begin bad++; $display("FAIL prio9_d1 seg=%b want 1111111", seg); end
        $display("test_priority x=8021->15 x=0200->9");
    endtask

    task automatic test_zero_disable;
        bit ok;
        @(negedge clk); x = '0;
        repeat (2) @(negedge clk);
        total++; if (valid !== 1'b0 || idx !== 4'd0) begin bad++; $display("FAIL zero_cap idx=%0d valid=%0b want 0/0", idx, valid); end
        wait_an(2'b10, ok);
        total++; if (!ok || seg !== BLANK) begin bad++; $display("FAIL zero_d0 seg=%b an=%b want blank/10", seg, an); end
        wait_an(2'b01, ok);
        total++; if (!ok || seg !== BLANK) begin bad++; $display("FAIL zero_d1 seg=%b an=%b want blank/01", seg, an); end
        @(negedge clk); x = 16'h0400; en = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (idx !== 4'd10 || valid !== 1'b1) begin bad++; $display("FAIL dis_cap idx=%0d valid=%0b want 10/1", idx, valid); end
        wait_an(2'b10, ok);
        total++; if (!ok || seg !== BLANK) begin bad++; $display("FAIL dis_d0 seg=%b want 1111111", seg); end
        wait_an(2'b01, ok);
        total++; if (!ok || seg !== BLANK) begin bad++; $display("FAIL dis_d1 seg=%b want 1111111", seg); end
        @(negedge clk); en = 1'b1;
        wait_an(2'b10, ok);
        total++; if (!ok || seg !== 7'b1000000) begin bad++; $display("FAIL en_d0 seg=%b want 1000000", seg); end
        wait_an(2'b01, ok);
        total++; if (!ok || seg !== 7'b1111001) begin bad++; $display("FAIL en_d1 seg=%b want 1111001", seg); end
        $display("test_zero_disable idx=%0d", idx);
    endtask

    task automatic test_hold;
        bit ok;
        @(negedge clk); x = 16'h0010;
        repeat (2) @(negedge clk);
        total++; if (idx !== 4'd4) begin bad++; $display("FAIL hold_pre idx=%0d want 4", idx); end
        hold = 1'b1; x = 16'h4000;
        @(negedge clk);
        total++; if (idx !== 4'd4 || valid !== 1'b1) begin bad++; $display("FAIL hold_same_cycle idx=%0d want 4", idx); end
        repeat (5) @(negedge clk);
        total++; if (idx !== 4'd4) begin bad++; $display("FAIL hold_keep idx=%0d want 4", idx); end
        wait_an(2'b10, ok);
        total++; if (!ok || seg !== 7'b0011001) begin bad++; $display("FAIL hold_d0 seg=%b want 0011001", seg); end
        wait_an(2'b01, ok);
        total++; if (!ok || seg !== BLANK) begin bad++; $display("FAIL hold_d1 seg=%b want 1111111", seg); end
        @(negedge clk); hold = 1'b0;
        @(negedge clk);
        total++; if (idx !== 4'd14) begin bad++; $display("FAIL hold_release idx=%0d want 14", idx); end
        $display("test_hold idx=%0d", idx);
    endtask

    task automatic test_sweep;
        bit ok;
        logic [N_IN-1:0] v;
        int exp_idx;
        bit exp_valid;
        for (int t = 0; t < N_IN + 8; t++) begin
            if (t < N_IN) v = N_IN'(1) << t;
            else          v = N_IN'($urandom);
            exp_idx = 0;
            for (int b = N_IN - 1; b >= 0; b--) begin
                if (v[b]) begin exp_idx = b; break; end
            end
            exp_valid = |v;
            @(negedge clk); x = v;
            @(negedge clk);
            total++; if (idx !== IDX_W'(exp_idx) || valid !== exp_valid) begin bad++; $display("FAIL sweep_cap x=%h idx=%0d valid=%0b want %0d/%0b", v, idx, valid, exp_idx, exp_valid); end
            wait_an(2'b10, ok);
            total++; if (!ok || seg !== ref_seg(exp_idx, exp_valid, 1'b1, 0)) begin bad++; $display("FAIL sweep_d0 x=%h seg=%b want %b", v, seg, ref_seg(exp_idx, exp_valid, 1'b1, 0)); end
            wait_an(2'b01, ok);
            total++; if (!ok || seg !== ref_seg(exp_idx, exp_valid, 1'b1, 1)) begin bad++; $display("FAIL sweep_d1 x=%h seg=%b want %b", v, seg, ref_seg(exp_idx, exp_valid, 1'b1, 1)); end
            $display("sweep x=%h idx=%0d", v, idx);
        end
    endtask

    task automatic test_reset_mid_scan;
        @(negedge clk); x = 16'h0001; en = 1'b1; hold = 1'b0;
        repeat (6) @(negedge clk);
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL midrst_pre valid=%0b want 1", valid); end
        #3 rst_n = 1'b0;
        #1;
        total++; if (idx !== 4'd0 || valid !== 1'b0 || an !== 2'b11 || seg !== BLANK) begin bad++; $display("FAIL midrst_async idx=%0d valid=%0b an=%b seg=%b want 0/0/11/1111111", idx, valid, an, seg); end
        @(negedge clk); rst_n = 1'b1;
        for (int k = 0; k < SCAN_DIV; k++) begin
            @(negedge clk);
            total++; if (an !== 2'b10) begin bad++; $display("FAIL midrst_digit0 cycle=%0d an=%b want 10", k, an); end
        end
        @(negedge clk);
        total++; if (an !== 2'b01) begin bad++; $display("FAIL midrst_digit1 an=%b want 01", an); end
        $display("test_reset_mid_scan done");
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_priority();
        test_zero_disable();
        test_hold();
        test_sweep();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
